// File: rtl/seven_seg_pkg.sv
// Shared types and segment encodings for the two-digit multiplexed display.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    S_D0 = 2'd0,
    S_G0 = 2'd1,
    S_D1 = 2'd2,
    S_G1 = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes 10..15 show 'E' so a decoder fault is visible on the panel.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Two-digit seven-segment scanner: ones, guard, tens, guard, repeating.
// state | meaning
// S_D0  | ones digit driven for DIV cycles
// S_G0  | all anodes off for GUARD cycles
// S_D1  | tens digit driven (or blanked as leading zero) for DIV cycles
// S_G1  | all anodes off for GUARD cycles
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] y1,
  input  logic [3:0] y0,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int              CW     = $clog2(DIV);
  localparam logic [CW-1:0]   D_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]   G_LAST = CW'(GUARD - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    d1;
  logic [3:0]    d0;
  logic [3:0]    digit;
  logic [6:0]    pattern;
  logic          last;

  // Single shared decoder; the mux only looks at registered digits.
  assign digit = (state == S_D1) ? d1 : d0;

  bcd_to_seg u_dec (
    .bcd (digit),
    .seg (pattern)
  );

  assign last = (state == S_D0 || state == S_D1) ? (cnt == D_LAST) : (cnt == G_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_D0;
      cnt   <= '0;
      d1    <= 4'd0;
      d0    <= 4'd0;
      seg   <= SEG_BLANK;
      an    <= 2'b11;
    end else begin
      if (load) begin
        d1 <= y1;
        d0 <= y0;
      end

      if (last) begin
        cnt <= '0;
        case (state)
          S_D0:    state <= S_G0;
          S_G0:    state <= S_D1;
          S_D1:    state <= S_G1;
          default: state <= S_D0;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Outputs follow the current state, so they trail it by one cycle.
      case (state)
        S_D0: begin
          an  <= 2'b10;
          seg <= pattern;
        end
        S_D1: begin
          if (blank_lz && d1 == 4'd0) begin
            an  <= 2'b11;
            seg <= SEG_BLANK;
          end else begin
            an  <= 2'b01;
            seg <= pattern;
          end
        end
        default: begin
          an  <= 2'b11;
          seg <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with DIV=4, GUARD=2 (12-cycle scan), plus a
// second instance with DIV=7, GUARD=3 for the scan period measurement.
module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       blank_lz = 1'b0;
  logic [3:0] y1 = 4'd0;
  logic [3:0] y0 = 4'd0;
  logic [6:0] seg, seg_b;
  logic [1:0] an, an_b;

  seven_seg_scan #(.DIV(4), .GUARD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .y1(y1), .y0(y0), .load(load),
    .blank_lz(blank_lz), .seg(seg), .an(an)
  );

  seven_seg_scan #(.DIV(7), .GUARD(3)) u_per (
    .clk(clk), .rst_n(rst_n), .y1(y1), .y0(y0), .load(load),
    .blank_lz(blank_lz), .seg(seg_b), .an(an_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
  } obs_t;

  typedef struct {
    logic [3:0] y1;
    logic [3:0] y0;
    logic       bl;
    logic [6:0] ones_seg;
    logic [1:0] tens_an;
    logic [6:0] tens_seg;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pos_out = 11;

  task automatic chk(input string nm, input logic [1:0] a, input logic [6:0] s,
                     input logic [1:0] ea, input logic [6:0] es);
    n_cmp++;
    if (a !== ea || s !== es) begin
      n_bad++;
      $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h (pos %0d)",
               nm, a, s, ea, es, pos_out);
    end
  endtask

  // Advance one clock; pos_out is the scan position the visible outputs show.
  task automatic step();
    @(posedge clk);
    #1;
    pos_out = (pos_out + 1) % 12;
    n_cmp++;
    if (an == 2'b00) begin
      n_bad++;
      $display("FAIL an_overlap: got an=%b, want not 00", an);
    end
  endtask

  task automatic step_to(input int p);
    for (int i = 0; i < 12; i++)
      if (pos_out != p) step();
  endtask

  task automatic push_period(input logic [6:0] ones, input logic [1:0] tan, input logic [6:0] tseg);
    for (int p = 0; p < 12; p++) begin
      if (p < 4)       sb.push_back('{an: 2'b10, seg: ones});
      else if (p < 6)  sb.push_back('{an: 2'b11, seg: 7'h7F});
      else if (p < 10) sb.push_back('{an: tan,   seg: tseg});
      else             sb.push_back('{an: 2'b11, seg: 7'h7F});
    end
  endtask

  task automatic check_period(input string nm);
    obs_t e;
    for (int i = 0; i < 12; i++) begin
      step();
      e = sb.pop_front();
      chk(nm, an, seg, e.an, e.seg);
    end
  endtask

  initial begin
    int c, t1, t2;
    logic prev;

    vecs[0] = '{4'd1,  4'd5,  1'b0, 7'h12, 2'b01, 7'h79};
    vecs[1] = '{4'd0,  4'd7,  1'b1, 7'h78, 2'b11, 7'h7F};
    vecs[2] = '{4'd0,  4'd7,  1'b0, 7'h78, 2'b01, 7'h40};
    vecs[3] = '{4'd3,  4'd12, 1'b0, 7'h06, 2'b01, 7'h30};
    vecs[4] = '{4'd15, 4'd9,  1'b1, 7'h10, 2'b01, 7'h06};
    vecs[5] = '{4'd8,  4'd2,  1'b0, 7'h24, 2'b01, 7'h00};
    vecs[6] = '{4'd6,  4'd4,  1'b0, 7'h19, 2'b01, 7'h02};

    // Reset state, and reset winning over a simultaneous load.
    repeat (2) @(posedge clk);
    #1;
    chk("reset", an, seg, 2'b11, 7'h7F);
    y1 = 4'd9; y0 = 4'd9; load = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_over_load", an, seg, 2'b11, 7'h7F);
    load = 1'b0;
    rst_n = 1'b1;
    pos_out = 11;
    step();
    chk("release_pos0", an, seg, 2'b10, 7'h40);
    step();
    chk("release_d0_zero", an, seg, 2'b10, 7'h40);

    foreach (vecs[k]) begin
      step_to(11);
      y1 = vecs[k].y1; y0 = vecs[k].y0; blank_lz = vecs[k].bl; load = 1'b1;
      step();
      load = 1'b0;
      step_to(11);
      push_period(vecs[k].ones_seg, vecs[k].tens_an, vecs[k].tens_seg);
      check_period($sformatf("vec%0d", k));
    end

    // Load in the middle of the ones phase: seg changes one cycle after capture.
    step_to(0);
    y0 = 4'd1; load = 1'b1;
    step();
    load = 1'b0;
    chk("mid_load_old", an, seg, 2'b10, 7'h19);
    step();
    chk("mid_load_new", an, seg, 2'b10, 7'h79);
    step();
    chk("mid_load_hold", an, seg, 2'b10, 7'h79);

    // Load on the last ones cycle: old pattern finishes, new one shows next scan.
    step_to(2);
    y0 = 4'd8; load = 1'b1;
    step();
    load = 1'b0;
    chk("edge_load_old", an, seg, 2'b10, 7'h79);
    step();
    chk("edge_load_guard", an, seg, 2'b11, 7'h7F);
    step();
    chk("edge_load_guard2", an, seg, 2'b11, 7'h7F);
    step_to(11);
    step();
    chk("edge_load_new", an, seg, 2'b10, 7'h00);

    // One-cycle reset during the tens phase.
    step_to(6);
    rst_n = 1'b0;
    step();
    chk("midscan_reset", an, seg, 2'b11, 7'h7F);
    rst_n = 1'b1;
    pos_out = 11;
    step();
    chk("midscan_restart", an, seg, 2'b10, 7'h40);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midscan_ones_len", an, seg, 2'b10, 7'h40);
    end
    step();
    chk("midscan_guard", an, seg, 2'b11, 7'h7F);
    step_to(5);
    step();
    chk("midscan_tens_zero", an, seg, 2'b01, 7'h40);

    // Scan period of the DIV=7/GUARD=3 instance: 2*(7+3) cycles.
    c = 0; t1 = -1; t2 = -1;
    prev = an_b[0];
    for (int i = 0; i < 100 && t2 < 0; i++) begin
      @(posedge clk);
      #1;
      c++;
      if (prev && !an_b[0]) begin
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
      prev = an_b[0];
    end
    n_cmp++;
    if (t2 < 0 || (t2 - t1) != 20) begin
      n_bad++;
      $display("FAIL scan_period: got %0d cycles (t1=%0d t2=%0d), want 20", t2 - t1, t1, t2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter DIV, default 50000, meaning clock cycles each digit is driven (1 kHz per digit at 50 MHz); legal range DIV >= 2.
REQ-002 Parameter GUARD, default 16, meaning all-anodes-off cycles between digits (anti-ghosting); legal range 1 <= GUARD < DIV.
REQ-003 clk  input  1  the one clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 y1  input  4  BCD tens digit from the binary-to-BCD decoder.
REQ-006 y0  input  4  BCD ones digit from the binary-to-BCD decoder.
REQ-007 load  input  1  strobe; y1/y0 captured on any edge where load=1.
REQ-008 blank_lz  input  1  1 = suppress tens digit when it is 0.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 an  output  2  digit enables, active-low, registered; an[0] = ones, an[1] = tens.

Function
REQ-011 Digit registers d1/d0 SHALL load y1/y0 on every edge with load=1 and hold otherwise.
REQ-012 FSM states SHALL be S_D0, S_G0, S_D1, S_G1, visited in that order and wrapping S_G1 -> S_D0.
REQ-013 Phase counter SHALL count 0..DIV-1 in S_D0/S_D1 and 0..GUARD-1 in S_G0/S_G1; advance state and clear to 0 at terminal count; scan period 2*(DIV+GUARD) cycles.
REQ-014 Outputs SHALL lag state by exactly one cycle (registered from current state and digit registers).
REQ-015 In S_D0: an=2'b10, seg=pattern(d0).
REQ-016 In S_D1: an=2'b01, seg=pattern(d1); if blank_lz=1 and d1=0, an=2'b11 and seg=7'h7F instead.
REQ-017 In S_G0/S_G1: an=2'b11, seg=7'h7F.
REQ-018 Patterns: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex); codes 10..15 SHALL display 'E'=06.
REQ-019 load coinciding with a phase change: the new digit SHALL appear at the next output update (registered value used, no bypass of y1/y0).
REQ-020 load while a digit is displayed SHALL change seg within that phase one cycle after capture; an SHALL NOT glitch.
REQ-021 At no cycle SHALL both an bits be 0.

Reset
REQ-022 When rst_n=0 at an edge: state=S_D0, counter=0, d1=d0=0, seg=7'h7F, an=2'b11.
REQ-023 Reset mid-scan SHALL abort the phase immediately; on the first edge with rst_n=1 outputs become an=2'b10, seg=7'h40.
REQ-024 Reset SHALL take priority over load.

Structure
REQ-025 Package seven_seg_pkg SHALL hold the state enum, the ten digit patterns, SEG_E and SEG_BLANK constants.
REQ-026 A combinational sub-module bcd_to_seg (4-bit BCD in, 7-bit active-low pattern out, invalid -> SEG_E) SHALL be instantiated once, fed by a mux selecting d0/d1.
REQ-027 No other clocks, latches or asynchronous logic.

Verification (DIV=4, GUARD=2, period 12)
REQ-028 Reset release, y1=1,y0=5 loaded -> an sequence 10 x4, 11 x2, 01 x4, 11 x2 repeating; seg=12 during an=10, 79 during an=01.
REQ-029 blank_lz=1, load y1=0,y0=7 -> tens phase an=11, seg=7F; ones phase seg=78; blank_lz=0 -> tens shows 40.
REQ-030 load y0=12 (invalid) -> ones phase seg=06.
REQ-031 load pulse on last S_D0 cycle with new y0 -> old pattern held through S_G0 (blank) and new value visible on next S_D0; assertion an!=2'b00 every cycle.
REQ-032 rst_n=0 for 1 cycle during S_D1 -> next cycle an=11, seg=7F, d1=d0=0; following cycle an=10, seg=40, scan restarts from counter 0.
REQ-033 Default parameters: count cycles between an[0] falling edges = 100032.
